// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB plus an MDU wait
// state, and drives datapath select codes and per-state write enables.
module multicycle_cu #(
    parameter int MUL_CYC  = 5,
    parameter int DIV_CYC  = 10,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt_op,
    input  logic [1:0] ACmpB,
    input  logic [1:0] ACmp0,
    output logic [2:0] state,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic       HIWr,
    output logic       LOWr,
    output logic       MDUStart,
    output logic [1:0] MDUOp,
    output logic [1:0] NPCOp,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] ALUBSel,
    output logic [1:0] GRFA3Sel,
    output logic [2:0] GRFWDSel,
    output logic [2:0] DMOp,
    output logic       busy,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDU    = 3'd5
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               taken_q, taken_nxt, taken_now, taken_eff;

    logic is_r;
    logic addu, subu, or_r, slt, sll, jr, jalr, mfhi, mthi, mflo, mtlo;
    logic mult, multu, div, divu;
    logic ori, lui, addiu, lw, lh, lb, lhu, lbu, sw, sh, sb;
    logic beq, bne, j, jal, bgezal;
    logic load, store, md, alu_i, known;

    assign is_r   = (op == 6'h00);
    assign addu   = is_r && (funct == 6'h21);
    assign subu   = is_r && (funct == 6'h23);
    assign or_r   = is_r && (funct == 6'h25);
    assign slt    = is_r && (funct == 6'h2A);
    assign sll    = is_r && (funct == 6'h00);
    assign jr     = is_r && (funct == 6'h08);
    assign jalr   = is_r && (funct == 6'h09);
    assign mfhi   = is_r && (funct == 6'h10);
    assign mthi   = is_r && (funct == 6'h11);
    assign mflo   = is_r && (funct == 6'h12);
    assign mtlo   = is_r && (funct == 6'h13);
    assign mult   = is_r && (funct == 6'h18);
    assign multu  = is_r && (funct == 6'h19);
    assign div    = is_r && (funct == 6'h1A);
    assign divu   = is_r && (funct == 6'h1B);
    assign ori    = (op == 6'h0D);
    assign lui    = (op == 6'h0F);
    assign addiu  = (op == 6'h09);
    assign lw     = (op == 6'h23);
    assign lh     = (op == 6'h21);
    assign lb     = (op == 6'h20);
    assign lhu    = (op == 6'h25);
    assign lbu    = (op == 6'h24);
    assign sw     = (op == 6'h2B);
    assign sh     = (op == 6'h29);
    assign sb     = (op == 6'h28);
    assign beq    = (op == 6'h04);
    assign bne    = (op == 6'h05);
    assign j      = (op == 6'h02);
    assign jal    = (op == 6'h03);
    assign bgezal = (op == 6'h01) && (rt_op == 5'h11);

    assign load  = lw | lh | lb | lhu | lbu;
    assign store = sw | sh | sb;
    assign md    = mult | multu | div | divu;
    assign alu_i = ori | lui | addiu;
    assign known = addu | subu | or_r | slt | sll | jr | jalr | mfhi | mthi | mflo | mtlo
                 | md | alu_i | load | store | beq | bne | j | jal | bgezal;

    assign taken_now = (beq && (ACmpB == 2'd0)) || (bne && (ACmpB != 2'd0))
                     || (bgezal && (ACmp0 != 2'd1));
    // DECODE sees the live comparison; later states use the latched outcome
    assign taken_eff = (state_q == S_DECODE) ? taken_now : taken_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            taken_q <= taken_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        taken_nxt = taken_q;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        RFWr      = 1'b0;
        DMWr      = 1'b0;
        HIWr      = 1'b0;
        LOWr      = 1'b0;
        MDUStart  = 1'b0;
        busy      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWr      = 1'b1;
                PCWr      = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                taken_nxt = taken_now;
                if (taken_now || j || jal || jr || jalr) PCWr = 1'b1;
                if (!known) begin
                    illegal   = 1'b1;
                    state_nxt = S_FETCH;
                end else if (jal || jalr || bgezal) begin
                    state_nxt = S_WB;
                end else if (beq || bne || j || jr) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (load || store) begin
                    cnt_nxt   = CNT_W'(MEM_WAIT);
                    state_nxt = S_MEM;
                end else if (md) begin
                    MDUStart  = 1'b1;
                    cnt_nxt   = (div || divu) ? CNT_W'(DIV_CYC - 1) : CNT_W'(MUL_CYC - 1);
                    state_nxt = S_MDU;
                end else if (mthi || mtlo) begin
                    HIWr      = mthi;
                    LOWr      = mtlo;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    DMWr      = store;
                    state_nxt = store ? S_FETCH : S_WB;
                end
            end
            S_MDU: begin
                busy = 1'b1;
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    HIWr      = 1'b1;
                    LOWr      = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                RFWr      = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        // Enables are killed combinationally so an abandoned MEM/MDU sequence never commits
        if (!reset) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            RFWr     = 1'b0;
            DMWr     = 1'b0;
            HIWr     = 1'b0;
            LOWr     = 1'b0;
            MDUStart = 1'b0;
            busy     = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

    always_comb begin
        EXTOp = !(ori || lui);

        ALUOp = 4'd0;
        if (subu)             ALUOp = 4'd1;
        else if (or_r || ori) ALUOp = 4'd2;
        else if (sll)         ALUOp = 4'd3;
        else if (lui)         ALUOp = 4'd4;
        else if (slt)         ALUOp = 4'd5;

        ALUBSel = 2'd0;
        if (sll)                         ALUBSel = 2'd2;
        else if (alu_i || load || store) ALUBSel = 2'd1;

        GRFA3Sel = 2'd0;
        if (jal || (bgezal && taken_eff)) GRFA3Sel = 2'd2;
        else if (bgezal)                  GRFA3Sel = 2'd3;
        else if (alu_i || load)           GRFA3Sel = 2'd1;

        GRFWDSel = 3'd0;
        if (load)                       GRFWDSel = 3'd1;
        else if (jal || jalr || bgezal) GRFWDSel = 3'd2;
        else if (mfhi)                  GRFWDSel = 3'd3;
        else if (mflo)                  GRFWDSel = 3'd4;

        DMOp = 3'd0;
        if (lh || sh)      DMOp = 3'd1;
        else if (lb || sb) DMOp = 3'd2;
        else if (lhu)      DMOp = 3'd3;
        else if (lbu)      DMOp = 3'd4;

        MDUOp = 2'd0;
        if (multu)     MDUOp = 2'd1;
        else if (div)  MDUOp = 2'd2;
        else if (divu) MDUOp = 2'd3;

        NPCOp = 2'd0;
        if (state_q != S_FETCH) begin
            if (j || jal)                                      NPCOp = 2'd2;
            else if (jr || jalr)                               NPCOp = 2'd3;
            else if ((beq || bne || bgezal) && taken_eff)      NPCOp = 2'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: per-instruction state/enable traces against hand-derived values.
module tb_multicycle_cu;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic [4:0] rt_op;
    logic [1:0] ACmpB, ACmp0;

    logic [2:0] state;
    logic       PCWr, IRWr, RFWr, DMWr, HIWr, LOWr, MDUStart, busy, illegal;
    logic [1:0] MDUOp, NPCOp, ALUBSel, GRFA3Sel;
    logic       EXTOp;
    logic [3:0] ALUOp;
    logic [2:0] GRFWDSel, DMOp;

    // second instance: MUL_CYC=1, permanently fed a mult
    logic [5:0] op1, funct1;
    logic [4:0] rt_op1;
    logic [2:0] state1;
    logic       PCWr1, IRWr1, RFWr1, DMWr1, HIWr1, LOWr1, MDUStart1, busy1, illegal1;
    logic [1:0] MDUOp1, NPCOp1, ALUBSel1, GRFA3Sel1;
    logic       EXTOp1;
    logic [3:0] ALUOp1;
    logic [2:0] GRFWDSel1, DMOp1;

    logic [8:0] en, en1;
    assign en  = {PCWr, IRWr, RFWr, DMWr, HIWr, LOWr, MDUStart, busy, illegal};
    assign en1 = {PCWr1, IRWr1, RFWr1, DMWr1, HIWr1, LOWr1, MDUStart1, busy1, illegal1};

    localparam logic [8:0] E_PC = 9'h100, E_IR = 9'h080, E_RF = 9'h040, E_DM = 9'h020,
                           E_HI = 9'h010, E_LO = 9'h008, E_MS = 9'h004, E_BZ = 9'h002,
                           E_IL = 9'h001;

    multicycle_cu #(.MUL_CYC(5), .DIV_CYC(10), .MEM_WAIT(2), .CNT_W(4)) u_dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rt_op(rt_op),
        .ACmpB(ACmpB), .ACmp0(ACmp0), .state(state),
        .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .HIWr(HIWr), .LOWr(LOWr),
        .MDUStart(MDUStart), .MDUOp(MDUOp), .NPCOp(NPCOp), .EXTOp(EXTOp), .ALUOp(ALUOp),
        .ALUBSel(ALUBSel), .GRFA3Sel(GRFA3Sel), .GRFWDSel(GRFWDSel), .DMOp(DMOp),
        .busy(busy), .illegal(illegal)
    );

    multicycle_cu #(.MUL_CYC(1), .DIV_CYC(10), .MEM_WAIT(0), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .op(op1), .funct(funct1), .rt_op(rt_op1),
        .ACmpB(ACmpB), .ACmp0(ACmp0), .state(state1),
        .PCWr(PCWr1), .IRWr(IRWr1), .RFWr(RFWr1), .DMWr(DMWr1), .HIWr(HIWr1), .LOWr(LOWr1),
        .MDUStart(MDUStart1), .MDUOp(MDUOp1), .NPCOp(NPCOp1), .EXTOp(EXTOp1), .ALUOp(ALUOp1),
        .ALUBSel(ALUBSel1), .GRFA3Sel(GRFA3Sel1), .GRFWDSel(GRFWDSel1), .DMOp(DMOp1),
        .busy(busy1), .illegal(illegal1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [8:0] en;
        logic [1:0] npc;
        logic [1:0] a3;
        logic [1:0] mduop;
        logic [2:0] wd;
        logic [2:0] dmop;
        logic [3:0] aluop;
        logic [2:0] st1;
        logic [8:0] en1;
    } snap_t;

    snap_t tr[0:31];
    int    n_vec = 0;
    int    n_err = 0;
    int    ncyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH, recording one snapshot per cycle
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                       output int n);
        op = o; funct = f; rt_op = r;
        n = 0;
        do begin
            tr[n].st    = state;     tr[n].en   = en;       tr[n].npc  = NPCOp;
            tr[n].a3    = GRFA3Sel;  tr[n].mduop = MDUOp;   tr[n].wd   = GRFWDSel;
            tr[n].dmop  = DMOp;      tr[n].aluop = ALUOp;
            tr[n].st1   = state1;    tr[n].en1  = en1;
            tick();
            n++;
        end while (state != 3'd0 && n < 32);
        check("end_in_fetch", {29'd0, state}, 32'd0);
    endtask

    initial begin
        int cnt_bz, cnt_hi, cnt_dm, cnt_mem;
        reset = 1'b0;
        op = 6'h00; funct = 6'h21; rt_op = 5'd0;
        ACmpB = 2'd0; ACmp0 = 2'd0;
        op1 = 6'h00; funct1 = 6'h18; rt_op1 = 5'd0;

        tick(); tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_en",    {23'd0, en},    32'd0);
        reset = 1'b1;
        #1;
        check("post_rst_fetch_en", {23'd0, en}, {23'd0, E_PC | E_IR});

        // addu
        run(6'h00, 6'h21, 5'd0, ncyc);
        check("addu_cyc", ncyc, 4);
        check("addu_st", {tr[0].st, tr[1].st, tr[2].st, tr[3].st}, {3'd0, 3'd1, 3'd2, 3'd4});
        check("addu_en_exec", {23'd0, tr[2].en}, 32'd0);
        check("addu_en_wb", {23'd0, tr[3].en}, {23'd0, E_RF});
        check("addu_sel_wb", {tr[3].a3, tr[3].wd, tr[3].aluop}, {2'd0, 3'd0, 4'd0});

        // subu, ori
        run(6'h00, 6'h23, 5'd0, ncyc);
        check("subu_aluop", {28'd0, tr[3].aluop}, 32'd1);
        run(6'h0D, 6'h00, 5'd0, ncyc);
        check("ori_sel", {tr[3].aluop, tr[3].a3, tr[3].en}, {4'd2, 2'd1, E_RF});

        // beq taken / not taken
        ACmpB = 2'd0;
        run(6'h04, 6'h00, 5'd0, ncyc);
        check("beq_t_cyc", ncyc, 2);
        check("beq_t_dec", {tr[1].en, tr[1].npc}, {E_PC, 2'd1});
        ACmpB = 2'd1;
        run(6'h04, 6'h00, 5'd0, ncyc);
        check("beq_nt_cyc", ncyc, 2);
        check("beq_nt_dec", {tr[1].en, tr[1].npc}, {9'd0, 2'd0});

        // bgezal not taken / taken
        ACmp0 = 2'd1;
        run(6'h01, 6'h00, 5'h11, ncyc);
        check("bgezal_nt_cyc", ncyc, 3);
        check("bgezal_nt_dec", {23'd0, tr[1].en}, 32'd0);
        check("bgezal_nt_wb", {tr[2].st, tr[2].a3, tr[2].en}, {3'd4, 2'd3, E_RF});
        ACmp0 = 2'd2;
        run(6'h01, 6'h00, 5'h11, ncyc);
        check("bgezal_t_dec", {tr[1].en, tr[1].npc}, {E_PC, 2'd1});
        check("bgezal_t_wb", {tr[2].a3, tr[2].wd}, {2'd2, 3'd2});

        // div
        run(6'h00, 6'h1A, 5'd0, ncyc);
        check("div_cyc", ncyc, 13);
        check("div_exec", {tr[2].st, tr[2].en, tr[2].mduop}, {3'd2, E_MS, 2'd2});
        cnt_bz = 0; cnt_hi = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (tr[i].en[1]) cnt_bz++;
            if (tr[i].en[4] && tr[i].en[3]) cnt_hi++;
        end
        check("div_busy_cnt", cnt_bz, 10);
        check("div_hilo_cnt", cnt_hi, 1);
        check("div_last", {23'd0, tr[12].en}, {23'd0, E_HI | E_LO | E_BZ});
        check("div_mid", {23'd0, tr[6].en}, {23'd0, E_BZ});

        run(6'h00, 6'h10, 5'd0, ncyc);
        check("mfhi_wb", {tr[3].wd, tr[3].en}, {3'd3, E_RF});

        // sw / lw with MEM_WAIT=2
        run(6'h2B, 6'h00, 5'd0, ncyc);
        check("sw_cyc", ncyc, 6);
        cnt_dm = 0; cnt_mem = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (tr[i].en[5]) cnt_dm++;
            if (tr[i].st == 3'd3) cnt_mem++;
        end
        check("sw_mem_cnt", cnt_mem, 3);
        check("sw_dm_cnt", cnt_dm, 1);
        check("sw_dm_last", {23'd0, tr[5].en}, {23'd0, E_DM});
        run(6'h23, 6'h00, 5'd0, ncyc);
        check("lw_cyc", ncyc, 7);
        check("lw_wb", {tr[6].st, tr[6].wd, tr[6].dmop, tr[6].a3}, {3'd4, 3'd1, 3'd0, 2'd1});
        run(6'h25, 6'h00, 5'd0, ncyc);
        check("lhu_dmop", {29'd0, tr[4].dmop}, 32'd3);

        // mthi
        run(6'h00, 6'h11, 5'd0, ncyc);
        check("mthi", {ncyc[3:0], tr[2].en}, {4'd3, E_HI});

        // illegal
        run(6'h3F, 6'h00, 5'd0, ncyc);
        check("ill_cyc", ncyc, 2);
        check("ill_dec", {23'd0, tr[1].en}, {23'd0, E_IL});

        // mult abandoned by reset in its 4th MDU cycle
        op = 6'h00; funct = 6'h18;
        tick(); tick(); tick(); tick(); tick(); tick();
        check("mdu4_state", {29'd0, state}, 32'd5);
        check("mdu4_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_en", {23'd0, en}, 32'd0);
        cnt_hi = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (HIWr || LOWr || DMWr) cnt_hi++;
        end
        check("abort_no_commit", cnt_hi, 0);
        #1;
        reset = 1'b1;
        #1;
        check("rel_fetch_en", {23'd0, en}, {23'd0, E_PC | E_IR});

        // addu on main while the MUL_CYC=1 instance runs its mult
        run(6'h00, 6'h21, 5'd0, ncyc);
        check("addu2_cyc", ncyc, 4);
        check("m1_exec", {tr[2].st1, tr[2].en1}, {3'd2, E_MS});
        check("m1_mdu", {tr[3].st1, tr[3].en1}, {3'd5, E_HI | E_LO | E_BZ});
        check("m1_back", {29'd0, state1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
